// File: rtl/pll_phase_stepper.sv
// ECP5 EHXPLLL dynamic phase sequencer: cmd -> setup, PHASESTEP pulses, optional PHASELOADREG, settle.
// Latency 1+SETUP+2*PULSE*(count+load)+SETTLE cycles; cmd_ready low while busy or unlocked.
module pll_phase_stepper #(
   parameter int OUT_DIV       = 15,
   parameter int POS_W         = 7,
   parameter int SETUP_CYCLES  = 2,
   parameter int PULSE_CYCLES  = 4,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               pll_locked,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_sel,
   input  logic               cmd_dir,
   input  logic [7:0]         cmd_count,
   input  logic               cmd_load,
   output logic               done,
   output logic               err,
   output logic [4*POS_W-1:0] phase_pos,
   output logic [1:0]         phasesel,
   output logic               phasedir,
   output logic               phasestep,
   output logic               phaseloadreg
);

   typedef enum logic [2:0] {
      WAIT_LOCK, IDLE, SETUP, STEP_LO, STEP_HI, LOAD_LO, LOAD_HI, SETTLE
   } state_t;

   localparam int PERIOD = 8 * OUT_DIV;
   localparam logic [POS_W-1:0] POS_MAX = POS_W'(PERIOD - 1);

   state_t            state, state_nxt;
   logic [15:0]       cnt, cnt_load;
   logic [7:0]        rem;
   logic              load_q;
   logic              accept, lock_loss, tick;
   logic [POS_W-1:0]  pos [4];

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid && cmd_ready && pll_locked;
   assign lock_loss = !pll_locked && (state != WAIT_LOCK);
   assign tick      = (cnt == 16'd0);

   always_ff @(posedge clk) begin
      if (!resetn) state <= WAIT_LOCK;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_LOCK: if (pll_locked) state_nxt = IDLE;
         IDLE:      if (accept) state_nxt = SETUP;
         SETUP, STEP_HI:
            if (tick) begin
               if (rem != 8'd0)  state_nxt = STEP_LO;
               else if (load_q)  state_nxt = LOAD_LO;
               else              state_nxt = SETTLE;
            end
         STEP_LO:   if (tick) state_nxt = STEP_HI;
         LOAD_LO:   if (tick) state_nxt = LOAD_HI;
         LOAD_HI:   if (tick) state_nxt = SETTLE;
         SETTLE:    if (tick) state_nxt = IDLE;
         default:   state_nxt = WAIT_LOCK;
      endcase
      // Lock loss overrides every in-flight transition, including an accept.
      if (lock_loss) state_nxt = WAIT_LOCK;
   end

   always_comb begin
      cnt_load = 16'd0;
      case (state_nxt)
         SETUP:                              cnt_load = 16'(SETUP_CYCLES - 1);
         STEP_LO, STEP_HI, LOAD_LO, LOAD_HI: cnt_load = 16'(PULSE_CYCLES - 1);
         SETTLE:                             cnt_load = 16'(SETTLE_CYCLES - 1);
         default:                            cnt_load = 16'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt          <= 16'd0;
         rem          <= 8'd0;
         load_q       <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         phasesel     <= 2'd0;
         phasedir     <= 1'b0;
         phasestep    <= 1'b1;
         phaseloadreg <= 1'b1;
         for (int k = 0; k < 4; k++) pos[k] <= '0;
      end else begin
         cnt          <= (state_nxt != state) ? cnt_load : (tick ? cnt : cnt - 16'd1);
         done         <= (state == SETTLE) && (state_nxt == IDLE);
         phasestep    <= (state_nxt != STEP_LO);
         phaseloadreg <= (state_nxt != LOAD_LO);
         if (accept) begin
            phasesel <= cmd_sel;
            phasedir <= cmd_dir;
            rem      <= cmd_count;
            load_q   <= cmd_load;
            err      <= 1'b0;
         end else if (lock_loss && state != IDLE) begin
            err <= 1'b1;
         end
         // Position advances together with the rising edge of PHASESTEP.
         if (state == STEP_LO && state_nxt == STEP_HI) begin
            rem <= rem - 8'd1;
            if (phasedir)
               pos[phasesel] <= (pos[phasesel] == POS_MAX) ? '0 : pos[phasesel] + 1'b1;
            else
               pos[phasesel] <= (pos[phasesel] == '0) ? POS_MAX : pos[phasesel] - 1'b1;
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_pos
      assign phase_pos[g*POS_W +: POS_W] = pos[g];
   end

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Directed table-driven bench for pll_phase_stepper with hand-computed latencies and positions.
module tb_pll_phase_stepper;

   logic        clk = 1'b0;
   logic        resetn, pll_locked, cmd_valid, cmd_dir, cmd_load;
   logic [1:0]  cmd_sel;
   logic [7:0]  cmd_count;
   logic        cmd_ready, done, err, phasedir, phasestep, phaseloadreg;
   logic [27:0] phase_pos;
   logic [1:0]  phasesel;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [1:0] sel;
      logic       dir;
      logic [7:0] cnt;
      logic       load;
      logic [6:0] exp;
      int         lat;
   } vec_t;

   vec_t       tbl [8];
   logic [6:0] model [4];
   logic       hold;
   logic [1:0] nxt_sel;
   logic       nxt_dir, nxt_load;
   logic [7:0] nxt_cnt;

   pll_phase_stepper dut (
      .clk(clk), .resetn(resetn), .pll_locked(pll_locked),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
      .cmd_dir(cmd_dir), .cmd_count(cmd_count), .cmd_load(cmd_load),
      .done(done), .err(err), .phase_pos(phase_pos), .phasesel(phasesel),
      .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] getpos(input int k);
      return phase_pos[k*7 +: 7];
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Called just after the accept edge; monitors until cmd_ready returns.
   task automatic watch(input logic [1:0] sel, input logic dir, input logic [7:0] cnt,
                        input logic load, input logic [6:0] exp, input int lat);
      int c = 0, ready_at = -1, early_done = 0, done_at_ready = 0;
      int s_falls = 0, s_low = 0, l_falls = 0, l_low = 0, first_fall = -1;
      int selbad = 0, posbad = 0;
      logic ps_prev = 1'b1, pl_prev = 1'b1;
      logic [6:0] pos_prev = '0;
      while (ready_at < 0 && c < 200) begin
         @(negedge clk);
         c++;
         if (c == 1) begin
            cmd_valid = hold;
            if (hold) begin
               cmd_sel = nxt_sel; cmd_dir = nxt_dir; cmd_count = nxt_cnt; cmd_load = nxt_load;
            end
            chk("err_cleared_on_accept", err, 0);
            pos_prev = getpos(sel);
         end
         if (!phasestep) begin
            s_low++;
            if (ps_prev) begin s_falls++; if (first_fall < 0) first_fall = c; end
         end
         if (!phaseloadreg) begin
            l_low++;
            if (pl_prev) begin l_falls++; if (first_fall < 0) first_fall = c; end
         end
         if (phasesel != sel || phasedir != dir) selbad++;
         if (phasestep && !ps_prev) begin
            if (getpos(sel) == pos_prev) posbad++;
         end else if (getpos(sel) != pos_prev) posbad++;
         ps_prev  = phasestep;
         pl_prev  = phaseloadreg;
         pos_prev = getpos(sel);
         if (cmd_ready) begin ready_at = c; done_at_ready = done; end
         else if (done) early_done++;
      end
      chk("ready_latency", ready_at, lat);
      chk("done_at_ready", done_at_ready, 1);
      chk("no_early_done", early_done, 0);
      chk("step_pulses", s_falls, cnt);
      chk("step_low_cycles", s_low, 4 * cnt);
      chk("load_pulses", l_falls, load);
      chk("load_low_cycles", l_low, 4 * load);
      if (cnt != 0 || load) chk("first_pulse_cycle", first_fall, 3);
      chk("sel_dir_stable", selbad, 0);
      chk("pos_moves_on_rise", posbad, 0);
      chk("err_after_cmd", err, 0);
      model[sel] = exp;
      for (int k = 0; k < 4; k++) chk($sformatf("pos%0d", k), getpos(k), model[k]);
   endtask

   task automatic issue(input vec_t v);
      cmd_valid = 1'b1; cmd_sel = v.sel; cmd_dir = v.dir; cmd_count = v.cnt; cmd_load = v.load;
      hold = 1'b0;
      @(posedge clk);
      watch(v.sel, v.dir, v.cnt, v.load, v.exp, v.lat);
   endtask

   initial begin
      int rises, guard, stray;
      vec_t v;
      tbl[0] = '{2'd1, 1'b1, 8'd3, 1'b0, 7'd3,   43};
      tbl[1] = '{2'd1, 1'b0, 8'd3, 1'b0, 7'd0,   43};
      tbl[2] = '{2'd1, 1'b0, 8'd5, 1'b0, 7'd115, 59};
      tbl[3] = '{2'd1, 1'b1, 8'd5, 1'b0, 7'd0,   59};
      tbl[4] = '{2'd0, 1'b0, 8'd0, 1'b1, 7'd0,   27};
      tbl[5] = '{2'd3, 1'b1, 8'd2, 1'b1, 7'd2,   43};
      tbl[6] = '{2'd2, 1'b0, 8'd1, 1'b0, 7'd119, 27};
      tbl[7] = '{2'd0, 1'b1, 8'd0, 1'b0, 7'd0,   19};
      for (int k = 0; k < 4; k++) model[k] = '0;
      hold = 1'b0; nxt_sel = '0; nxt_dir = 1'b0; nxt_cnt = '0; nxt_load = 1'b0;

      resetn = 1'b0; pll_locked = 1'b0; cmd_valid = 1'b0;
      cmd_sel = '0; cmd_dir = 1'b0; cmd_count = '0; cmd_load = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_phasestep", phasestep, 1);
      chk("rst_phaseloadreg", phaseloadreg, 1);
      chk("rst_phase_pos", int'(phase_pos), 0);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_done_err", {done, err}, 0);
      chk("rst_sel_dir", {phasesel, phasedir}, 0);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      chk("wait_lock_ready", cmd_ready, 0);
      pll_locked = 1'b1;
      @(negedge clk);
      chk("ready_after_lock", cmd_ready, 1);

      for (int i = 0; i < 8; i++) issue(tbl[i]);

      // Lock loss after the fourth completed step of a ten-step command.
      cmd_valid = 1'b1; cmd_sel = 2'd0; cmd_dir = 1'b1; cmd_count = 8'd10; cmd_load = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      rises = 0; guard = 0;
      while (rises < 4 && guard < 200) begin
         logic prev;
         prev = phasestep;
         @(negedge clk);
         guard++;
         if (phasestep && !prev) rises++;
      end
      chk("lockloss_rises_seen", rises, 4);
      pll_locked = 1'b0;
      @(negedge clk);
      chk("lockloss_phasestep", phasestep, 1);
      chk("lockloss_phaseloadreg", phaseloadreg, 1);
      chk("lockloss_err", err, 1);
      chk("lockloss_ready", cmd_ready, 0);
      chk("lockloss_pos0", getpos(0), 4);
      model[0] = 7'd4;
      stray = 0;
      repeat (30) begin
         @(negedge clk);
         if (done || !phasestep || cmd_ready) stray++;
      end
      chk("lockloss_quiet", stray, 0);
      pll_locked = 1'b1;
      @(negedge clk);
      chk("relock_ready", cmd_ready, 1);
      chk("relock_err_sticky", err, 1);
      v = '{2'd0, 1'b0, 8'd4, 1'b0, 7'd0, 51};
      issue(v);

      // Back-to-back: second command queued behind the first with cmd_valid held high.
      hold = 1'b1; nxt_sel = 2'd2; nxt_dir = 1'b1; nxt_cnt = 8'd1; nxt_load = 1'b0;
      cmd_valid = 1'b1; cmd_sel = 2'd1; cmd_dir = 1'b1; cmd_count = 8'd2; cmd_load = 1'b0;
      @(posedge clk);
      watch(2'd1, 1'b1, 8'd2, 1'b0, 7'd2, 35);
      hold = 1'b0;
      @(posedge clk);
      watch(2'd2, 1'b1, 8'd1, 1'b0, 7'd0, 27);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
